// File: rtl/cfu_pkg.sv
// Shared definitions for the MAC custom-function unit and its dot-product sequencer.
package cfu_pkg;

  localparam logic [9:0] FUNC_MAC         = 10'd0;
  localparam logic [9:0] FUNC_CLR         = 10'd1;
  localparam logic [9:0] FUNC_SET_IN_OFF  = 10'd2;
  localparam logic [9:0] FUNC_SET_FLT_OFF = 10'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET_IN,
    S_SET_FLT,
    S_CLR,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } seq_state_t;

  // 9-bit signed offset widened to a full command operand.
  function automatic logic [31:0] sext9(input logic [8:0] v);
    return {{23{v[8]}}, v};
  endfunction

endpackage

// File: rtl/cfu_dot_sequencer_if.sv
// Command/response channel between the sequencer (master) and the MAC unit (slave).
interface cfu_dot_sequencer_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_function_id;
  logic [31:0] cmd_inputs_0;
  logic [31:0] cmd_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload;

  modport master (
    output cmd_valid, cmd_function_id, cmd_inputs_0, cmd_inputs_1, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_payload
  );

  modport slave (
    input  cmd_valid, cmd_function_id, cmd_inputs_0, cmd_inputs_1, rsp_ready,
    output cmd_ready, rsp_valid, rsp_payload
  );

endinterface

// File: rtl/cfu_dot_sequencer.sv
// Walks the MAC unit through offset setup, accumulator clear and one MAC per
// packed word pair, then reports the final accumulator with a done pulse.
module cfu_dot_sequencer
  import cfu_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] flt_base,
  input  logic [8:0]        input_offset,
  input  logic [8:0]        filter_offset,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result,
  output logic [ADDR_W-1:0] in_addr,
  output logic [ADDR_W-1:0] flt_addr,
  output logic              mem_rd,
  input  logic [31:0]       in_rdata,
  input  logic [31:0]       flt_rdata,
  cfu_dot_sequencer_if.master bus
);

  localparam logic [LEN_W-1:0] IDX_ONE = LEN_W'(1);

  seq_state_t        state_q, state_d;
  seq_state_t        ret_q, ret_d;        // where W goes once the response lands
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] in_base_q, in_base_d;
  logic [ADDR_W-1:0] flt_base_q, flt_base_d;
  logic [8:0]        flt_off_q, flt_off_d;
  logic [ADDR_W-1:0] in_addr_q, in_addr_d;
  logic [ADDR_W-1:0] flt_addr_q, flt_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [9:0]        func_q, func_d;
  logic [31:0]       pay0_q, pay0_d;
  logic [31:0]       pay1_q, pay1_d;
  logic              fresh_q, fresh_d;    // first ISSUE cycle: read data is on the bus now
  logic              rsp_ready_q, rsp_ready_d;
  logic [31:0]       result_q, result_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  // Next-state and registered-output computation for the whole sequencer.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    len_d       = len_q;
    idx_d       = idx_q;
    in_base_d   = in_base_q;
    flt_base_d  = flt_base_q;
    flt_off_d   = flt_off_q;
    in_addr_d   = in_addr_q;
    flt_addr_d  = flt_addr_q;
    mem_rd_d    = 1'b0;
    cmd_valid_d = cmd_valid_q;
    func_d      = func_q;
    pay0_d      = pay0_q;
    pay1_d      = pay1_q;
    fresh_d     = 1'b0;
    rsp_ready_d = rsp_ready_q;
    result_d    = result_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d       = len;
          in_base_d   = in_base;
          flt_base_d  = flt_base;
          flt_off_d   = filter_offset;
          idx_d       = '0;
          cmd_valid_d = 1'b1;
          func_d      = FUNC_SET_IN_OFF;
          pay0_d      = sext9(input_offset);
          pay1_d      = '0;
          ret_d       = S_SET_FLT;
          state_d     = S_SET_IN;
        end
      end

      S_SET_IN, S_SET_FLT, S_CLR, S_ISSUE: begin
        // Latch the word pair so it survives any later buffer activity.
        if (fresh_q) begin
          pay0_d = in_rdata;
          pay1_d = flt_rdata;
        end
        if (cmd_valid_q && bus.cmd_ready) begin
          cmd_valid_d = 1'b0;
          rsp_ready_d = 1'b1;
          state_d     = S_WAIT;
          if (state_q == S_ISSUE) idx_d = idx_q + IDX_ONE;
        end
      end

      S_WAIT: begin
        if (bus.rsp_valid) begin
          rsp_ready_d = 1'b0;
          case (ret_q)
            S_SET_FLT: begin
              cmd_valid_d = 1'b1;
              func_d      = FUNC_SET_FLT_OFF;
              pay0_d      = sext9(flt_off_q);
              pay1_d      = '0;
              ret_d       = S_CLR;
              state_d     = S_SET_FLT;
            end
            S_CLR: begin
              cmd_valid_d = 1'b1;
              func_d      = FUNC_CLR;
              pay0_d      = '0;
              pay1_d      = '0;
              ret_d       = S_FETCH;
              state_d     = S_CLR;
            end
            default: begin
              if (idx_q == len_q) begin
                // Final response is the finished accumulator; an empty run reports 0.
                state_d  = S_DONE;
                done_d   = 1'b1;
                result_d = (len_q == '0) ? '0 : bus.rsp_payload;
              end else begin
                state_d    = S_FETCH;
                mem_rd_d   = 1'b1;
                in_addr_d  = in_base_q + idx_q[ADDR_W-1:0];
                flt_addr_d = flt_base_q + idx_q[ADDR_W-1:0];
              end
            end
          endcase
        end
      end

      S_FETCH: begin
        state_d     = S_ISSUE;
        cmd_valid_d = 1'b1;
        func_d      = FUNC_MAC;
        fresh_d     = 1'b1;
        ret_d       = S_FETCH;
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset returns everything to an idle, quiet bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ret_q       <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      in_base_q   <= '0;
      flt_base_q  <= '0;
      flt_off_q   <= '0;
      in_addr_q   <= '0;
      flt_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      cmd_valid_q <= 1'b0;
      func_q      <= '0;
      pay0_q      <= '0;
      pay1_q      <= '0;
      fresh_q     <= 1'b0;
      rsp_ready_q <= 1'b0;
      result_q    <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      in_base_q   <= in_base_d;
      flt_base_q  <= flt_base_d;
      flt_off_q   <= flt_off_d;
      in_addr_q   <= in_addr_d;
      flt_addr_q  <= flt_addr_d;
      mem_rd_q    <= mem_rd_d;
      cmd_valid_q <= cmd_valid_d;
      func_q      <= func_d;
      pay0_q      <= pay0_d;
      pay1_q      <= pay1_d;
      fresh_q     <= fresh_d;
      rsp_ready_q <= rsp_ready_d;
      result_q    <= result_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign in_addr  = in_addr_q;
  assign flt_addr = flt_addr_q;
  assign mem_rd   = mem_rd_q;

  assign bus.cmd_valid       = cmd_valid_q;
  assign bus.cmd_function_id = func_q;
  // Buffer data arrives during the first ISSUE cycle and is held from then on.
  assign bus.cmd_inputs_0    = fresh_q ? in_rdata  : pay0_q;
  assign bus.cmd_inputs_1    = fresh_q ? flt_rdata : pay1_q;
  assign bus.rsp_ready       = rsp_ready_q;

endmodule

// File: tb/tb_cfu_dot_sequencer.sv
// Bench for cfu_dot_sequencer: MAC engine model + buffers, reference dot product
// computed from the buffers, per-cycle compare process, directed and random runs.
module tb_cfu_dot_sequencer;
  import cfu_pkg::*;

  localparam int ADDR_W = 10;
  localparam int LEN_W  = 11;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic [ADDR_W-1:0] in_base = '0, flt_base = '0;
  logic [8:0]        input_offset = '0, filter_offset = '0;
  logic              busy, done, mem_rd;
  logic [31:0]       result;
  logic [ADDR_W-1:0] in_addr, flt_addr;
  logic [31:0]       in_rdata, flt_rdata;

  logic [31:0] in_mem  [DEPTH];
  logic [31:0] flt_mem [DEPTH];

  int checks = 0, errors = 0;
  int cyc = 0;
  bit rand_mode = 0, stall_en = 0, ideal = 1;
  int extra = 0;

  always #5 clk = ~clk;

  cfu_dot_sequencer_if bus();

  cfu_dot_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_base(in_base), .flt_base(flt_base),
    .input_offset(input_offset), .filter_offset(filter_offset),
    .busy(busy), .done(done), .result(result),
    .in_addr(in_addr), .flt_addr(flt_addr), .mem_rd(mem_rd),
    .in_rdata(in_rdata), .flt_rdata(flt_rdata), .bus(bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int lane_dot(logic [31:0] a, logic [31:0] b, int ioff, int foff);
    int s;
    s = 0;
    for (int l = 0; l < 4; l++)
      s += (int'($signed(a[8*l +: 8])) + ioff) * (int'($signed(b[8*l +: 8])) + foff);
    return s;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Operand buffers: synchronous read, data one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd) begin
      in_rdata  <= in_mem[in_addr];
      flt_rdata <= flt_mem[flt_addr];
    end
  end

  // MAC engine model.
  int   e_acc, e_ioff, e_foff, wait_c, next_dly, stall_seen, mac_acc;
  logic pend, rdy_r, stall_now, accept;

  always_comb begin
    stall_now = stall_en && bus.cmd_valid && (bus.cmd_function_id == FUNC_MAC) &&
                (mac_acc == 1) && (stall_seen < 5);
    bus.cmd_ready = rdy_r && !stall_now;
    accept = bus.cmd_valid && bus.cmd_ready;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e_acc <= 0; e_ioff <= 0; e_foff <= 0; wait_c <= 0; next_dly <= 0;
      stall_seen <= 0; mac_acc <= 0; pend <= 1'b0; rdy_r <= 1'b0;
      bus.rsp_valid <= 1'b0; bus.rsp_payload <= '0;
    end else begin
      rdy_r    <= rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      next_dly <= rand_mode ? int'($urandom_range(0, 3)) : 0;
      if (stall_now) stall_seen <= stall_seen + 1;
      if (accept) begin
        pend          <= 1'b1;
        wait_c        <= next_dly;
        bus.rsp_valid <= (next_dly == 0);
        case (bus.cmd_function_id)
          FUNC_MAC: begin
            e_acc           <= e_acc + lane_dot(bus.cmd_inputs_0, bus.cmd_inputs_1, e_ioff, e_foff);
            bus.rsp_payload <= e_acc + lane_dot(bus.cmd_inputs_0, bus.cmd_inputs_1, e_ioff, e_foff);
            mac_acc         <= mac_acc + 1;
          end
          FUNC_CLR: begin
            e_acc <= 0; bus.rsp_payload <= '0; mac_acc <= 0; stall_seen <= 0;
          end
          FUNC_SET_IN_OFF:  begin e_ioff <= int'($signed(bus.cmd_inputs_0)); bus.rsp_payload <= '0; end
          default:          begin e_foff <= int'($signed(bus.cmd_inputs_0)); bus.rsp_payload <= '0; end
        endcase
      end else if (pend) begin
        if (bus.rsp_valid && bus.rsp_ready) begin
          pend <= 1'b0; bus.rsp_valid <= 1'b0;
        end else if (!bus.rsp_valid) begin
          if (wait_c <= 1) bus.rsp_valid <= 1'b1;
          wait_c <= wait_c - 1;
        end
      end else begin
        // Stray responses while nothing is outstanding must be ignored.
        bus.rsp_valid   <= rand_mode && ($urandom_range(0, 4) == 0);
        bus.rsp_payload <= $urandom;
      end
    end
  end

  // Compare process: reference run captured at start, checked every cycle.
  int   c_len, c_ib, c_fb, c_io, c_fo, ref_res, cmd_n, rd_n, s_cyc, last_dcyc, dones = 0;
  bit   run_on = 0, prev_hold = 0, prev_done = 0;
  logic [9:0]  prev_id;
  logic [31:0] prev_p0, prev_p1, ex0, ex1;
  logic [9:0]  exid;
  int   id_log[$];
  int   addr_log[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (prev_done) chk("busy_falls", {31'b0, busy}, 32'd0);
      prev_done = done;
      if (start && !busy) begin
        c_len = int'(len); c_ib = int'(in_base); c_fb = int'(flt_base);
        c_io = int'($signed(input_offset)); c_fo = int'($signed(filter_offset));
        ref_res = 0;
        for (int w = 0; w < c_len; w++)
          ref_res += lane_dot(in_mem[(c_ib + w) % DEPTH], flt_mem[(c_fb + w) % DEPTH], c_io, c_fo);
        if (c_len == 0) ref_res = 0;
        s_cyc = cyc; cmd_n = 0; rd_n = 0; run_on = 1;
        id_log.delete(); addr_log.delete();
      end
      if (bus.cmd_valid && prev_hold) begin
        chk("hold_id", {22'b0, bus.cmd_function_id}, {22'b0, prev_id});
        chk("hold_p0", bus.cmd_inputs_0, prev_p0);
        chk("hold_p1", bus.cmd_inputs_1, prev_p1);
      end
      prev_hold = bus.cmd_valid && !bus.cmd_ready;
      prev_id = bus.cmd_function_id; prev_p0 = bus.cmd_inputs_0; prev_p1 = bus.cmd_inputs_1;
      if (accept) begin
        case (cmd_n)
          0:       begin exid = FUNC_SET_IN_OFF;  ex0 = c_io; ex1 = 0; end
          1:       begin exid = FUNC_SET_FLT_OFF; ex0 = c_fo; ex1 = 0; end
          2:       begin exid = FUNC_CLR;         ex0 = 0;    ex1 = 0; end
          default: begin
            exid = FUNC_MAC;
            ex0 = in_mem[(c_ib + cmd_n - 3) % DEPTH];
            ex1 = flt_mem[(c_fb + cmd_n - 3) % DEPTH];
          end
        endcase
        chk("cmd_in_run", {31'b0, run_on}, 32'd1);
        chk("cmd_id", {22'b0, bus.cmd_function_id}, {22'b0, exid});
        chk("cmd_p0", bus.cmd_inputs_0, ex0);
        chk("cmd_p1", bus.cmd_inputs_1, ex1);
        id_log.push_back(int'(bus.cmd_function_id));
        cmd_n++;
      end
      if (mem_rd) begin
        chk("in_addr", {22'b0, in_addr}, 32'((c_ib + rd_n) % DEPTH));
        chk("flt_addr", {22'b0, flt_addr}, 32'((c_fb + rd_n) % DEPTH));
        addr_log.push_back(int'(in_addr));
        rd_n++;
      end
      if (done) begin
        chk("done_in_run", {31'b0, run_on}, 32'd1);
        chk("result", result, ref_res);
        chk("busy_at_done", {31'b0, busy}, 32'd1);
        chk("cmd_count", cmd_n, 3 + c_len);
        chk("rd_count", rd_n, c_len);
        last_dcyc = cyc - s_cyc;
        if (ideal) chk("done_cycle", last_dcyc, 7 + 3 * c_len + extra);
        run_on = 0; dones++;
      end
    end else begin
      run_on = 0; prev_hold = 0; prev_done = 0;
    end
  end

  task automatic run(input int n, input int ib, input int fb, input int io, input int fo, input bit hold);
    bit got;
    @(posedge clk); #2;
    len = n[LEN_W-1:0]; in_base = ib[ADDR_W-1:0]; flt_base = fb[ADDR_W-1:0];
    input_offset = io[8:0]; filter_offset = fo[8:0]; start = 1'b1;
    if (!hold) begin @(posedge clk); #2; start = 1'b0; end
    got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    start = 1'b0;
    chk("done_seen", {31'b0, got}, 32'd1);
    @(posedge clk); #2;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
    chk({tag, "_done"}, {31'b0, done}, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_addr"}, {12'b0, in_addr, flt_addr}, 0);
    chk({tag, "_mem_rd"}, {31'b0, mem_rd}, 0);
    chk({tag, "_cmd_valid"}, {31'b0, bus.cmd_valid}, 0);
    chk({tag, "_rsp_ready"}, {31'b0, bus.rsp_ready}, 0);
    chk({tag, "_func"}, {22'b0, bus.cmd_function_id}, 0);
    chk({tag, "_p0"}, bus.cmd_inputs_0, 0);
    chk({tag, "_p1"}, bus.cmd_inputs_1, 0);
  endtask

  initial begin
    int d0;
    bit found;
    for (int i = 0; i < DEPTH; i++) begin in_mem[i] = 0; flt_mem[i] = 0; end
    repeat (3) @(posedge clk); #2;
    chk_quiet("reset");
    reset = 1'b0;
    repeat (3) @(posedge clk);

    // Single word, exact result.
    in_mem[5] = 32'h01020304; flt_mem[9] = 32'h01010101;
    run(1, 5, 9, 0, 0, 0);
    chk("t1_result", result, 32'd10);
    chk("t1_ref", ref_res, 32'd10);
    chk("t1_cycle", last_dcyc, 32'd10);
    chk("t1_ncmd", id_log.size(), 32'd4);
    if (id_log.size() == 4) begin
      chk("t1_id0", id_log[0], 32'd2); chk("t1_id1", id_log[1], 32'd3);
      chk("t1_id2", id_log[2], 32'd1); chk("t1_id3", id_log[3], 32'd0);
    end

    // Offsets cancel the -128 input bytes.
    for (int i = 0; i < 4; i++) begin in_mem[100 + i] = 32'h80808080; flt_mem[200 + i] = 32'h7F7F7F7F; end
    run(4, 100, 200, 128, 0, 0);
    chk("t2_result", result, 32'd0);

    // Large accumulation.
    for (int i = 0; i < 4; i++) begin in_mem[300 + i] = 32'h7F7F7F7F; flt_mem[400 + i] = 32'h7F7F7F7F; end
    run(4, 300, 400, 0, 0, 0);
    chk("t3_result", result, 32'h0003F010);
    chk("t3_ref", ref_res, 32'd258064);
    if (addr_log.size() == 4) chk("t3_last_addr", addr_log[3], 32'd303);
    else chk("t3_naddr", addr_log.size(), 32'd4);

    // Backpressure on the second MAC.
    in_mem[50] = 32'h11223344; in_mem[51] = 32'hF0E0D0C0;
    flt_mem[60] = 32'h05FB07F9; flt_mem[61] = 32'h80017F02;
    stall_en = 1; extra = 5;
    run(2, 50, 60, -3, 17, 0);
    chk("t4_cycle", last_dcyc, 32'd18);
    stall_en = 0; extra = 0;

    // Empty run.
    run(0, 7, 8, 5, 5, 0);
    chk("t5_result", result, 32'd0);
    chk("t5_cycle", last_dcyc, 32'd7);
    chk("t5_nrd", addr_log.size(), 32'd0);

    // Start held high for the whole run.
    d0 = dones;
    run(2, 50, 60, 1, -1, 1);
    repeat (8) @(posedge clk); #2;
    chk("t6_one_run", dones - d0, 32'd1);
    chk("t6_idle", {31'b0, busy}, 32'd0);

    // Address wrap.
    in_mem[1023] = 32'h01FF7F80; in_mem[0] = 32'h12345678;
    flt_mem[1022] = 32'h03030303; flt_mem[1023] = 32'hFEFEFEFE;
    run(2, 1023, 1022, 0, 2, 0);
    if (addr_log.size() == 2) begin
      chk("t7_addr0", addr_log[0], 32'd1023); chk("t7_addr1", addr_log[1], 32'd0);
    end else chk("t7_naddr", addr_log.size(), 32'd2);

    // Reset in the middle of a MAC issue.
    @(posedge clk); #2;
    len = 3; in_base = 300; flt_base = 400; input_offset = 0; filter_offset = 0; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus.cmd_valid && bus.cmd_function_id == FUNC_MAC) found = 1;
    end
    chk("t8_found_issue", {31'b0, found}, 32'd1);
    #1 reset = 1'b1;
    #1 chk_quiet("t8_async");
    @(posedge clk); #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    run(1, 5, 9, 0, 0, 0);
    chk("t8_result", result, 32'd10);

    // Randomized runs with random backpressure, response delays and stray responses.
    for (int i = 0; i < DEPTH; i++) begin in_mem[i] = $urandom; flt_mem[i] = $urandom; end
    rand_mode = 1; ideal = 0;
    for (int r = 0; r < 14; r++)
      run(int'($urandom_range(0, 8)), int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
          int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256, r[0]);
    rand_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
